// File: rtl/muldiv_rs_param.sv
// Multiply/divide and HI/LO-move reservation station with age-ordered selection.
// Mult/div ops are offered to the iterative unit; mfhi/mflo ops request the CDB.
module muldiv_rs_param #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned TW    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [2:0]                   issue_op,
  input  logic [DW-1:0]                issue_vj,
  input  logic [DW-1:0]                issue_vk,
  input  logic [TW-1:0]                issue_qj,
  input  logic [TW-1:0]                issue_qk,
  input  logic [TW-1:0]                issue_tag,
  input  logic                         cdb_valid,
  input  logic [TW-1:0]                cdb_tag,
  input  logic [DW-1:0]                cdb_lo,
  input  logic [DW-1:0]                cdb_hi,
  output logic                         exe_valid,
  input  logic                         exe_ready,
  output logic [DW-1:0]                exe_a,
  output logic [DW-1:0]                exe_b,
  output logic [1:0]                   exe_op,
  output logic [TW-1:0]                exe_tag,
  output logic                         wb_req,
  input  logic                         wb_grant,
  output logic [TW-1:0]                wb_tag,
  output logic [DW-1:0]                wb_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [2:0]  OP_MFHI = 3'b100;

  logic [DEPTH-1:0] valid_q;
  logic [2:0]       op_q  [DEPTH];
  logic [DW-1:0]    vj_q  [DEPTH];
  logic [DW-1:0]    vk_q  [DEPTH];
  logic [TW-1:0]    qj_q  [DEPTH];
  logic [TW-1:0]    qk_q  [DEPTH];
  logic [TW-1:0]    tag_q [DEPTH];
  // age_q[i][j] set means entry j was issued before entry i
  logic [DEPTH-1:0] age_q [DEPTH];

  logic [DEPTH-1:0] exe_cand, wb_cand, free_mask;
  logic [IW-1:0]    exe_sel, wb_sel, ins_sel;
  logic             exe_any, wb_any, ins_any;
  logic [CW-1:0]    cnt;
  logic             full, issue_fire, exe_fire, wb_fire;
  logic             ij_hit, ik_hit;
  logic [DW-1:0]    ij_val;

  always_comb begin
    exe_cand = '0;
    wb_cand  = '0;
    exe_sel  = '0;
    wb_sel   = '0;
    ins_sel  = '0;
    exe_any  = 1'b0;
    wb_any   = 1'b0;
    ins_any  = 1'b0;
    cnt      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      exe_cand[i] = valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0) && !op_q[i][2];
      wb_cand[i]  = valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0) &&  op_q[i][2];
      cnt         = cnt + CW'(valid_q[i]);
    end
    // The oldest candidate is the only one with no older candidate in its age vector
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!exe_any && exe_cand[i] && ((age_q[i] & exe_cand) == '0)) begin
        exe_any = 1'b1;
        exe_sel = IW'(i);
      end
      if (!wb_any && wb_cand[i] && ((age_q[i] & wb_cand) == '0)) begin
        wb_any = 1'b1;
        wb_sel = IW'(i);
      end
      if (!ins_any && !valid_q[i]) begin
        ins_any = 1'b1;
        ins_sel = IW'(i);
      end
    end
  end

  assign count       = cnt;
  assign full        = (cnt == CW'(DEPTH));
  assign issue_ready = !full && !flush;
  assign issue_fire  = issue_valid && issue_ready && ins_any;

  assign exe_valid = exe_any && !flush;
  assign exe_a     = vj_q[exe_sel];
  assign exe_b     = vk_q[exe_sel];
  assign exe_op    = op_q[exe_sel][1:0];
  assign exe_tag   = tag_q[exe_sel];
  assign wb_req    = wb_any && !flush;
  assign wb_tag    = tag_q[wb_sel];
  assign wb_data   = vj_q[wb_sel];

  assign exe_fire = exe_valid && exe_ready;
  assign wb_fire  = wb_req && wb_grant;

  always_comb begin
    free_mask = '0;
    if (exe_fire) free_mask[exe_sel] = 1'b1;
    if (wb_fire)  free_mask[wb_sel]  = 1'b1;
  end

  assign ij_hit = cdb_valid && (issue_qj != '0) && (cdb_tag == issue_qj);
  assign ik_hit = cdb_valid && (issue_qk != '0) && (cdb_tag == issue_qk);
  assign ij_val = (issue_op == OP_MFHI) ? cdb_hi : cdb_lo;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cdb_valid && (qj_q[i] != '0) && (qj_q[i] == cdb_tag)) begin
          vj_q[i] <= (op_q[i] == OP_MFHI) ? cdb_hi : cdb_lo;
          qj_q[i] <= '0;
        end
        if (valid_q[i] && cdb_valid && (qk_q[i] != '0) && (qk_q[i] == cdb_tag)) begin
          vk_q[i] <= cdb_lo;
          qk_q[i] <= '0;
        end
        if (free_mask[i]) valid_q[i] <= 1'b0;
        age_q[i] <= age_q[i] & ~free_mask;
      end
      if (issue_fire) begin
        valid_q[ins_sel] <= 1'b1;
        op_q[ins_sel]    <= issue_op;
        vj_q[ins_sel]    <= ij_hit ? ij_val : issue_vj;
        qj_q[ins_sel]    <= ij_hit ? '0 : issue_qj;
        vk_q[ins_sel]    <= ik_hit ? cdb_lo : issue_vk;
        qk_q[ins_sel]    <= ik_hit ? '0 : issue_qk;
        tag_q[ins_sel]   <= issue_tag;
        // Entries leaving this edge must not look older than the newcomer later
        age_q[ins_sel]   <= valid_q & ~free_mask;
      end
    end
  end

endmodule
